fft_bfly_sched: RTL

- Operand-side sequencer for the in-place radix-2 DIT burst FFT engine.
- For each stage it generates butterfly read addresses for the data RAM and the twiddle ROM address. It then drives the butterfly issue signals (mult_en, first_lev_s, fft_i_index) aligned with the returned memory data.
- It counts butterfly completions returned from the datapath (dat_out_vld) and blocks the next stage until the current stage has fully drained, which avoids in-place RAM hazards.

---
 rtl/fft_bfly_sched.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fft_bfly_sched.sv
// Operand-side butterfly sequencer for the in-place radix-2 DIT FFT engine.
// Issues one butterfly read per cycle and holds each stage until all of its results return.
module fft_bfly_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            cfg_log2n,
  input  logic                  bfly_vld,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  output logic                  mult_en,
  output logic                  first_lev_s,
  output logic [ADDR_WIDTH-1:0] fft_i_index,
  output logic [4:0]            stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | one butterfly read per cycle, k = 0 .. N/2-1
  // DRAIN | reads stopped, waiting for the rest of the stage's results
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            log2n, stage, lm1;
  logic [ADDR_WIDTH-1:0] k, ret_cnt, half, span, pos, grp, addr_a;
  logic [ADDR_WIDTH-2:0] tw;
  logic                  cfg_ok, issue, last_k, last_stage, drained, overflow;

  logic                  vld_pipe  [RAM_RD_LAT];
  logic                  flev_pipe [RAM_RD_LAT];
  logic [ADDR_WIDTH-1:0] idx_pipe  [RAM_RD_LAT];

  assign cfg_ok     = (cfg_log2n != 5'd0) && (cfg_log2n <= 5'(ADDR_WIDTH));
  assign lm1        = log2n - 5'd1;
  assign half       = ADDR_WIDTH'(1) << lm1;
  assign span       = ADDR_WIDTH'(1) << stage;
  assign pos        = k & (span - ADDR_WIDTH'(1));
  assign grp        = k >> stage;
  assign addr_a     = (grp << (stage + 5'd1)) | pos;
  assign tw         = (ADDR_WIDTH-1)'(pos << (lm1 - stage));
  assign issue      = (state == ISSUE);
  assign last_k     = (k == half - ADDR_WIDTH'(1));
  assign last_stage = (stage == lm1);
  // ret_cnt saturates at half, so an early-full count also releases the stage
  assign drained    = (ret_cnt == half) || ((ret_cnt + ADDR_WIDTH'(bfly_vld)) == half);
  assign overflow   = bfly_vld && (ret_cnt == half) && (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && cfg_ok) state_nxt = ISSUE;
      ISSUE:   if (last_k) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = last_stage ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      log2n   <= '0;
      stage   <= '0;
      k       <= '0;
      ret_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= overflow || ((state == IDLE) && start && !cfg_ok);
      if ((state == IDLE) && start && cfg_ok) begin
        log2n   <= cfg_log2n;
        stage   <= '0;
        k       <= '0;
        ret_cnt <= '0;
      end
      if (issue) k <= k + ADDR_WIDTH'(1);
      if ((issue || (state == DRAIN)) && bfly_vld && (ret_cnt != half))
        ret_cnt <= ret_cnt + ADDR_WIDTH'(1);
      if ((state == DRAIN) && drained && !last_stage) begin
        stage   <= stage + 5'd1;
        k       <= '0;
        ret_cnt <= '0;
      end
    end
  end

  // Issue strobes delayed to line up with the RAM/ROM read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_RD_LAT; i++) begin
        vld_pipe[i]  <= 1'b0;
        flev_pipe[i] <= 1'b0;
        idx_pipe[i]  <= '0;
      end
    end else begin
      vld_pipe[0]  <= issue;
      flev_pipe[0] <= issue && (stage == 5'd0);
      idx_pipe[0]  <= rd_addr_a;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        flev_pipe[i] <= flev_pipe[i-1];
        idx_pipe[i]  <= idx_pipe[i-1];
      end
    end
  end

  assign rd_en       = issue;
  assign rd_addr_a   = issue ? addr_a : '0;
  assign rd_addr_b   = issue ? (addr_a + span) : '0;
  assign tw_addr     = issue ? tw : '0;
  assign mult_en     = vld_pipe[RAM_RD_LAT-1];
  assign first_lev_s = flev_pipe[RAM_RD_LAT-1];
  assign fft_i_index = idx_pipe[RAM_RD_LAT-1];
  assign stage_idx   = stage;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule
